// File: rtl/nibble_feeder_if.sv
// Byte handshake between an upstream producer and the nibble feeder.
// Combinational bundle, no latency of its own.
// Transfer occurs when in_valid and in_ready are both high at a rising clk edge.
interface nibble_feeder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/nibble_feeder.sv
// Buffers bytes in a FIFO and feeds them low-nibble-first to a 4-in/8-out shift register.
// Latency: byte pushed at edge k -> shift_en in cycles k+2,k+3, byte_done in k+4.
// Backpressure: in_ready low when FIFO full or flush high; optional parity via NIBBLE_FEEDER_PARITY_EN.
module nibble_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_feeder_if.slave              up_if,
    input  logic                        flush_i,
    output logic [3:0]                  nib_out_o,
    output logic                        shift_en_o,
    output logic                        byte_done_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
`ifdef NIBBLE_FEEDER_PARITY_EN
    ,
    output logic                        par_out_o
`endif
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]      GAP_LD   = 4'(GAP_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    head_dat;

    logic [1:0]    state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [3:0]    gap_q, gap_d;
    logic          byte_done_q;

    assign fifo_empty     = (count_q == '0);
    assign head_dat       = mem_q[rd_ptr_q];
    assign up_if.in_ready = (count_q < FULL_CNT) & ~flush_i;
    assign push           = up_if.in_valid & up_if.in_ready;

    assign fifo_count_o = count_q;
    assign busy_o       = (state_q != S_IDLE) | ~fifo_empty;
    assign byte_done_o  = byte_done_q;

    // FIFO storage: write only on an accepted transfer, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= up_if.in_data;
        end
    end

    // FIFO pointers and occupancy; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state logic: pop into the hold register whenever a new byte may start.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = head_dat;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                state_d = S_HI;
            end
            S_HI: begin
                if (GAP_CYCLES > 0) begin
                    gap_d   = GAP_LD;
                    state_d = S_GAP;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = head_dat;
                    state_d = S_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                // gap_q==1 marks the last of the GAP_CYCLES idle cycles
                if (gap_q <= 4'd1) begin
                    gap_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        hold_d  = head_dat;
                        state_d = S_LO;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            gap_d   = '0;
            pop     = 1'b0;
        end
    end

    // FSM state, hold byte and gap counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    // Completion pulse follows HI by one cycle; a flush during HI abandons the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_done_q <= 1'b0;
        end else begin
            byte_done_q <= (state_q == S_HI) & ~flush_i;
        end
    end

    // Downstream drive: nibble and shift strobe only in LO and HI.
    always_comb begin
        shift_en_o = 1'b0;
        nib_out_o  = 4'h0;
        case (state_q)
            S_LO: begin
                shift_en_o = 1'b1;
                nib_out_o  = hold_q[3:0];
            end
            S_HI: begin
                shift_en_o = 1'b1;
                nib_out_o  = hold_q[7:4];
            end
            default: begin
                shift_en_o = 1'b0;
                nib_out_o  = 4'h0;
            end
        endcase
    end

`ifdef NIBBLE_FEEDER_PARITY_EN
    logic par_hold_q;
    logic par_out_q;

    // Parity is captured with the byte at pop and presented alongside byte_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_hold_q <= 1'b0;
            par_out_q  <= 1'b0;
        end else begin
            if (pop) par_hold_q <= ^head_dat;
            par_out_q <= ((state_q == S_HI) & ~flush_i) ? par_hold_q : 1'b0;
        end
    end

    assign par_out_o = par_out_q;
`endif

endmodule
